// File: rtl/sobel_stream.sv
// rtl/sobel_stream.sv - streaming 3x3 Sobel edge filter with frame-aware border gating
// Two-stage pipeline: window capture on accepted pixels, then gradient and mode select.
module sobel_stream #(
   parameter int DATA_WIDTH = 12,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_valid,
   input  logic                  i_sof,
   input  logic [DATA_WIDTH-1:0] i_pixel,
   input  logic [1:0]            i_mode,
   output logic                  o_valid,
   output logic [DATA_WIDTH+2:0] o_pixel,
   output logic                  o_eol,
   output logic                  o_eof
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam int GW = DATA_WIDTH + 3;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);

   logic [CW-1:0]         col, pos_col;
   logic [RW-1:0]         row, pos_row;
   logic [1:0]            mode, pos_mode;
   logic                  complete;
   logic [DATA_WIDTH-1:0] line1 [IMG_WIDTH];
   logic [DATA_WIDTH-1:0] line2 [IMG_WIDTH];
   logic [DATA_WIDTH-1:0] up1, up2;
   logic [DATA_WIDTH-1:0] win [3][3];
   logic                  s1_valid, s1_eol, s1_eof;
   logic [1:0]            s1_mode;

   // A start-of-frame pixel overrides the counters and loads the frame's mode.
   assign pos_col  = i_sof ? '0 : col;
   assign pos_row  = i_sof ? '0 : row;
   assign pos_mode = i_sof ? i_mode : mode;
   assign complete = i_valid && (pos_row >= ROW_TWO) && (pos_col >= COL_TWO);
   assign up1      = line1[pos_col];
   assign up2      = line2[pos_col];

   always_ff @(posedge i_clk) begin
      if (i_valid) begin
         line1[pos_col] <= i_pixel;
         line2[pos_col] <= up1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         col      <= '0;
         row      <= '0;
         mode     <= '0;
         s1_valid <= 1'b0;
         s1_eol   <= 1'b0;
         s1_eof   <= 1'b0;
         s1_mode  <= '0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               win[r][c] <= '0;
      end else begin
         s1_valid <= complete;
         s1_eol   <= (pos_col == COL_LAST);
         s1_eof   <= (pos_col == COL_LAST) && (pos_row == ROW_LAST);
         s1_mode  <= pos_mode;
         if (i_valid) begin
            mode <= pos_mode;
            if (pos_col == COL_LAST) begin
               col <= '0;
               row <= (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
            end else begin
               col <= pos_col + 1'b1;
               row <= pos_row;
            end
            for (int r = 0; r < 3; r++) begin
               win[r][0] <= win[r][1];
               win[r][1] <= win[r][2];
            end
            win[0][2] <= up2;
            win[1][2] <= up1;
            win[2][2] <= i_pixel;
         end
      end
   end

   function automatic logic [GW-2:0] ext(input logic [DATA_WIDTH-1:0] v);
      return {2'b00, v};
   endfunction

   function automatic logic [GW-2:0] dbl(input logic [DATA_WIDTH-1:0] v);
      return {1'b0, v, 1'b0};
   endfunction

   // Each weighted side sum is non-negative, so |G| is the larger minus the smaller.
   logic [GW-2:0] gx_pos, gx_neg, gy_pos, gy_neg, ax, ay;
   logic [GW-1:0] result;

   assign gx_pos = ext(win[0][2]) + dbl(win[1][2]) + ext(win[2][2]);
   assign gx_neg = ext(win[0][0]) + dbl(win[1][0]) + ext(win[2][0]);
   assign gy_pos = ext(win[2][0]) + dbl(win[2][1]) + ext(win[2][2]);
   assign gy_neg = ext(win[0][0]) + dbl(win[0][1]) + ext(win[0][2]);
   assign ax     = (gx_pos >= gx_neg) ? gx_pos - gx_neg : gx_neg - gx_pos;
   assign ay     = (gy_pos >= gy_neg) ? gy_pos - gy_neg : gy_neg - gy_pos;

   always_comb begin
      result = '0;
      case (s1_mode)
         2'd0:    result = {1'b0, ax};
         2'd1:    result = {1'b0, ay};
         2'd2:    result = {1'b0, ax} + {1'b0, ay};
         default: result = (ax >= ay) ? {1'b0, ax} : {1'b0, ay};
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid <= 1'b0;
         o_pixel <= '0;
         o_eol   <= 1'b0;
         o_eof   <= 1'b0;
      end else begin
         o_valid <= s1_valid;
         o_eol   <= s1_valid & s1_eol;
         o_eof   <= s1_valid & s1_eof;
         if (s1_valid)
            o_pixel <= result;
      end
   end

endmodule

// File: tb/tb_sobel_stream.sv
// tb/tb_sobel_stream.sv - scoreboard bench for sobel_stream on a 5x4 frame
module tb_sobel_stream;

   localparam int DW = 12;
   localparam int IW = 5;
   localparam int IH = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_valid = 1'b0;
   logic          i_sof = 1'b0;
   logic [DW-1:0] i_pixel = '0;
   logic [1:0]    i_mode = '0;
   logic          o_valid;
   logic [DW+2:0] o_pixel;
   logic          o_eol;
   logic          o_eof;

   sobel_stream #(.DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_valid (i_valid),
      .i_sof   (i_sof),
      .i_pixel (i_pixel),
      .i_mode  (i_mode),
      .o_valid (o_valid),
      .o_pixel (o_pixel),
      .o_eol   (o_eol),
      .o_eof   (o_eof)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [DW+2:0] pix;
      logic          eol;
      logic          eof;
      int            due;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   img [IH][IW];
   int   fmode = 0;
   int   compared = 0;
   int   mismatched = 0;
   int   got = 0;
   int   exp_count = 0;
   int   req_id = 0;
   int   ack_id = 0;

   function automatic int model(input int r, input int c, input int m);
      int tl, tm, tr, ml, mr, bl, bm, br, gx, gy, ax, ay;
      tl = img[r-2][c-2]; tm = img[r-2][c-1]; tr = img[r-2][c];
      ml = img[r-1][c-2];                     mr = img[r-1][c];
      bl = img[r][c-2];   bm = img[r][c-1];   br = img[r][c];
      gx = (tr + 2*mr + br) - (tl + 2*ml + bl);
      gy = (bl + 2*bm + br) - (tl + 2*tm + tr);
      ax = (gx < 0) ? -gx : gx;
      ay = (gy < 0) ? -gy : gy;
      case (m)
         0:       return ax;
         1:       return ay;
         2:       return ax + ay;
         default: return (ax > ay) ? ax : ay;
      endcase
   endfunction

   // Output monitor: pops the scoreboard, checks reset values and per-frame counts on request.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         compared = compared + 4;
         assert (o_valid === 1'b0) else begin mismatched++; $error("FAIL reset_valid: got %b expected 0", o_valid); end
         assert (o_pixel === '0) else begin mismatched++; $error("FAIL reset_pixel: got %0d expected 0", o_pixel); end
         assert (o_eol === 1'b0) else begin mismatched++; $error("FAIL reset_eol: got %b expected 0", o_eol); end
         assert (o_eof === 1'b0) else begin mismatched++; $error("FAIL reset_eof: got %b expected 0", o_eof); end
      end else if (o_valid) begin
         got++;
         compared++;
         assert (sb.size() > 0) else begin mismatched++; $error("FAIL unexpected_valid: got o_valid=1 at cycle %0d expected none", cyc); end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            compared = compared + 4;
            assert (o_pixel === e.pix) else begin mismatched++; $error("FAIL pixel: got %0d expected %0d", o_pixel, e.pix); end
            assert (o_eol === e.eol) else begin mismatched++; $error("FAIL eol: got %b expected %b", o_eol, e.eol); end
            assert (o_eof === e.eof) else begin mismatched++; $error("FAIL eof: got %b expected %b", o_eof, e.eof); end
            assert (cyc === e.due) else begin mismatched++; $error("FAIL latency: got cycle %0d expected %0d", cyc, e.due); end
         end
      end else begin
         compared++;
         assert (o_eol === 1'b0 && o_eof === 1'b0) else begin mismatched++; $error("FAIL idle_flags: got eol=%b eof=%b expected 0 0", o_eol, o_eof); end
      end
      if (rst_n && req_id != ack_id) begin
         ack_id = req_id;
         compared = compared + 2;
         assert (got === exp_count) else begin mismatched++; $error("FAIL frame_count: got %0d expected %0d", got, exp_count); end
         assert (sb.size() === 0) else begin mismatched++; $error("FAIL missing_results: got %0d pending expected 0", sb.size()); end
         got = 0;
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         i_valid = 1'b0;
         i_sof   = 1'b0;
      end
   endtask

   task automatic drive_px(input int r, input int c, input int p, input bit sof, input logic [1:0] m);
      exp_t x;
      @(posedge clk); #1;
      i_valid = 1'b1;
      i_sof   = sof;
      i_pixel = DW'(p);
      i_mode  = m;
      img[r][c] = p;
      if (sof) fmode = int'(m);
      if (r >= 2 && c >= 2) begin
         x.pix = 15'(model(r, c, fmode));
         x.eol = (c == IW-1);
         x.eof = (c == IW-1) && (r == IH-1);
         x.due = cyc + 2;
         sb.push_back(x);
      end
   endtask

   function automatic int pix_of(input int kind, input int r, input int c);
      case (kind)
         0:       return 100;
         1:       return c * 10;
         2:       return (r >= 2) ? 4095 : 0;
         default: return int'($urandom_range(0, 4095));
      endcase
   endfunction

   task automatic send_frame(input int kind, input logic [1:0] m, input logic [1:0] m_late,
                             input int switch_at, input bit bubbles, input int npix);
      for (int i = 0; i < npix; i++) begin
         if (bubbles)
            while ($urandom_range(0, 99) >= 40) idle(1);
         drive_px(i / IW, i % IW, pix_of(kind, i / IW, i % IW), i == 0,
                  (i >= switch_at) ? m_late : m);
      end
   endtask

   task automatic check_frame(input int n);
      idle(4);
      exp_count = n;
      req_id++;
      idle(2);
   endtask

   initial begin
      rst_n = 1'b0;
      idle(3);
      rst_n = 1'b1;
      idle(2);

      send_frame(0, 2'd2, 2'd2, 99, 1'b0, IW*IH); check_frame(6);
      for (int m = 0; m < 4; m++) begin
         send_frame(1, 2'(m), 2'(m), 99, 1'b0, IW*IH); check_frame(6);
      end
      send_frame(2, 2'd1, 2'd1, 99, 1'b0, IW*IH); check_frame(6);
      send_frame(2, 2'd2, 2'd2, 99, 1'b0, IW*IH); check_frame(6);
      send_frame(3, 2'd2, 2'd2, 99, 1'b1, IW*IH); check_frame(6);
      send_frame(3, 2'd3, 2'd3, 99, 1'b1, IW*IH); check_frame(6);

      send_frame(1, 2'd0, 2'd1, 10, 1'b0, IW*IH); check_frame(6);
      send_frame(1, 2'd1, 2'd1, 99, 1'b0, IW*IH); check_frame(6);

      send_frame(3, 2'd2, 2'd2, 99, 1'b0, 13);
      @(posedge clk); #1;
      i_valid = 1'b0;
      i_sof   = 1'b0;
      rst_n   = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2);
      send_frame(3, 2'd2, 2'd2, 99, 1'b0, IW*IH); check_frame(6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
